// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state codes and
// default operand/counter widths.
package mult_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_CWIDTH = $clog2(DEF_WIDTH + 1);
  localparam int unsigned STATE_W    = 3;

  // Controller states; codes 5-7 are unused and recover to S_IDLE.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Request/result bundle of the multiplier: start + operands in, product and
// status out. The requester uses the master modport, the multiplier the slave.
interface seq_shift_add_multiplier_if #(
  parameter int unsigned WIDTH = 4
);

  logic                 start;
  logic [WIDTH-1:0]     data_in_1;
  logic [WIDTH-1:0]     data_in_2;
  logic [2*WIDTH-1:0]   o_product;
  logic                 busy;
  logic                 done;

  modport master (
    output start, data_in_1, data_in_2,
    input  o_product, busy, done
  );

  modport slave (
    input  start, data_in_1, data_in_2,
    output o_product, busy, done
  );

endinterface

// File: rtl/seq_shift_add_multiplier_datapath.sv
// Datapath of the shift-and-add multiplier: accumulator A (with carry bit),
// multiplier register Q, multiplicand register M, adder, shifter, iteration
// down-counter and the registered product output.
module mult_datapath #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CWIDTH = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 add_en,
  input  logic                 shift_en,
  input  logic [WIDTH-1:0]     m_in,
  input  logic [WIDTH-1:0]     q_in,
  output logic                 q0,
  output logic                 z_cnt,
  output logic [2*WIDTH-1:0]   product,
  output logic [CWIDTH-1:0]    count
);

  logic [WIDTH:0]     a;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   m;
  logic [CWIDTH-1:0]  cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;

  // Adder keeps the carry out in sum[WIDTH]; shifter moves it into A[WIDTH-1].
  always_comb begin
    sum     = {1'b0, a[WIDTH-1:0]} + {1'b0, m};
    shifted = {a, q} >> 1;
  end

  // The product register is written on the final shift so that it is already
  // valid in the DONE cycle, when done is asserted.
  always_ff @(posedge clk) begin
    if (clr) begin
      a    <= '0;
      q    <= '0;
      m    <= '0;
      cnt  <= '0;
      prod <= '0;
    end else if (load) begin
      a   <= '0;
      q   <= q_in;
      m   <= m_in;
      cnt <= CWIDTH'(WIDTH);
    end else if (add_en) begin
      if (q[0]) begin
        a <= sum;
      end
    end else if (shift_en) begin
      {a, q} <= shifted;
      cnt    <= cnt - 1'b1;
      if (cnt == CWIDTH'(1)) begin
        prod <= shifted[2*WIDTH-1:0];
      end
    end
  end

  // Status back to the controller and debug/result outputs.
  always_comb begin
    q0      = q[0];
    z_cnt   = (cnt == CWIDTH'(1));
    product = prod;
    count   = cnt;
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: controller FSM plus
// mult_datapath. One ADD/SHIFT pair per multiplier bit; done pulses for one
// cycle with the product valid on o_product.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned CWIDTH = $clog2(WIDTH + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  seq_shift_add_multiplier_if.slave bus,
  output logic [STATE_W-1:0]        p_STATE,
  output logic [CWIDTH-1:0]         Count_out
);

  state_t state;
  state_t state_next;

  logic load;
  logic add_en;
  logic shift_en;
  logic clr;
  logic q0;
  logic z_cnt;

  // State register; reset overrides any in-flight operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_next = S_IDLE;
    load       = 1'b0;
    add_en     = 1'b0;
    shift_en   = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    clr        = i_rst;
    unique case (state)
      S_IDLE: begin
        state_next = bus.start ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        load       = 1'b1;
        bus.busy   = 1'b1;
        state_next = S_ADD;
      end
      S_ADD: begin
        add_en     = 1'b1;
        bus.busy   = 1'b1;
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en   = 1'b1;
        bus.busy   = 1'b1;
        state_next = z_cnt ? S_DONE : S_ADD;
      end
      S_DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  mult_datapath #(
    .WIDTH  (WIDTH),
    .CWIDTH (CWIDTH)
  ) u_datapath (
    .clk      (i_clk),
    .clr      (clr),
    .load     (load),
    .add_en   (add_en),
    .shift_en (shift_en),
    .m_in     (bus.data_in_1),
    .q_in     (bus.data_in_2),
    .q0       (q0),
    .z_cnt    (z_cnt),
    .product  (bus.o_product),
    .count    (Count_out)
  );

  // Debug export of the current state code.
  always_comb begin
    p_STATE = state;
  end

  // q0 is consumed inside the datapath's add decision; kept as a debug tap.
  logic unused_q0;
  always_comb unused_q0 = q0;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: table of operand pairs with
// hand-computed products, then multi-cycle sequences for reset, start while
// busy, and back-to-back operation over all operand pairs.
module tb_seq_shift_add_multiplier;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned CWIDTH = 3;

  logic              i_clk;
  logic              i_rst;
  logic [2:0]        p_STATE;
  logic [CWIDTH-1:0] Count_out;

  int n_checks = 0;
  int n_fail   = 0;

  seq_shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_shift_add_multiplier #(
    .WIDTH  (WIDTH),
    .CWIDTH (CWIDTH)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .bus       (bus),
    .p_STATE   (p_STATE),
    .Count_out (Count_out)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] p;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Wait (bounded) for IDLE, issue one start, return done latency and product.
  task automatic run_mult(input logic [3:0] m, input logic [3:0] q,
                          output int lat, output logic [7:0] prod);
    int guard;
    guard = 0;
    while (p_STATE != 3'd0 && guard < 30) begin
      tick();
      guard++;
    end
    bus.start     = 1'b1;
    bus.data_in_1 = m;
    bus.data_in_2 = q;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 30) begin
      tick();
      lat++;
    end
    if (!bus.done) begin
      lat = -1;
    end
    prod = bus.o_product;
  endtask

  initial begin
    int lat;
    logic [7:0] prod;
    int pulses;
    int last_done;
    int cyc;
    int guard;
    logic [3:0] mm;
    logic [3:0] qq;

    vecs[0] = '{m: 4'd13, q: 4'd11, p: 8'd143};
    vecs[1] = '{m: 4'd15, q: 4'd15, p: 8'd225};
    vecs[2] = '{m: 4'd0,  q: 4'd13, p: 8'd0};
    vecs[3] = '{m: 4'd9,  q: 4'd0,  p: 8'd0};
    vecs[4] = '{m: 4'd1,  q: 4'd1,  p: 8'd1};
    vecs[5] = '{m: 4'd15, q: 4'd1,  p: 8'd15};
    vecs[6] = '{m: 4'd10, q: 4'd12, p: 8'd120};
    vecs[7] = '{m: 4'd8,  q: 4'd8,  p: 8'd64};

    i_rst         = 1'b1;
    bus.start     = 1'b0;
    bus.data_in_1 = '0;
    bus.data_in_2 = '0;
    tick();
    tick();
    check("reset_state",   int'(p_STATE),       0);
    check("reset_product", int'(bus.o_product), 0);
    check("reset_count",   int'(Count_out),     0);
    check("reset_busy",    int'(bus.busy),      0);
    check("reset_done",    int'(bus.done),      0);
    i_rst = 1'b0;
    tick();

    // Table-driven single operations
    for (int i = 0; i < 8; i++) begin
      run_mult(vecs[i].m, vecs[i].q, lat, prod);
      check($sformatf("vec%0d_product", i), int'(prod), int'(vecs[i].p));
      check($sformatf("vec%0d_latency", i), lat, 10);
      check($sformatf("vec%0d_count", i), int'(Count_out), 0);
      check($sformatf("vec%0d_busy", i), int'(bus.busy), 1);
    end
    tick();
    check("idle_after_done_state", int'(p_STATE), 0);
    check("idle_after_done_pulse", int'(bus.done), 0);
    check("product_held", int'(bus.o_product), 64);

    // Reset during the second ADD discards the operation
    bus.start     = 1'b1;
    bus.data_in_1 = 4'd7;
    bus.data_in_2 = 4'd6;
    tick();
    bus.start = 1'b0;
    tick();  // LOAD
    tick();  // ADD #1
    tick();  // SHIFT #1
    check("mid_state_add2", int'(p_STATE), 2);
    i_rst = 1'b1;
    tick();
    check("midrst_state",   int'(p_STATE),       0);
    check("midrst_product", int'(bus.o_product), 0);
    check("midrst_count",   int'(Count_out),     0);
    check("midrst_busy",    int'(bus.busy),      0);
    check("midrst_done",    int'(bus.done),      0);
    i_rst = 1'b0;
    tick();
    run_mult(4'd3, 4'd5, lat, prod);
    check("after_rst_product", int'(prod), 15);
    check("after_rst_latency", lat, 10);

    // Start pulse during SHIFT is ignored; exactly one done pulse
    tick();
    bus.start     = 1'b1;
    bus.data_in_1 = 4'd5;
    bus.data_in_2 = 4'd5;
    tick();
    bus.start = 1'b0;
    tick();  // LOAD -> ADD
    tick();  // SHIFT
    check("busy_state_shift", int'(p_STATE), 3);
    bus.start     = 1'b1;
    bus.data_in_1 = 4'd2;
    bus.data_in_2 = 4'd2;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    prod   = '0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done) begin
        pulses++;
        prod = bus.o_product;
      end
      tick();
    end
    check("ignored_start_pulses",  pulses,      1);
    check("ignored_start_product", int'(prod), 25);
    check("ignored_start_idle",    int'(p_STATE), 0);

    // Exhaustive, start held high: back-to-back operations
    bus.data_in_1 = 4'd0;
    bus.data_in_2 = 4'd0;
    bus.start     = 1'b1;
    cyc       = 0;
    last_done = -1;
    for (int idx = 0; idx < 256; idx++) begin
      mm    = 4'(idx >> 4);
      qq    = 4'(idx);
      guard = 0;
      while (!bus.done && guard < 30) begin
        tick();
        cyc++;
        guard++;
      end
      if (!bus.done) begin
        check("exh_timeout", 0, 1);
        break;
      end
      check($sformatf("exh_%0dx%0d", mm, qq), int'(bus.o_product), int'(mm) * int'(qq));
      if (last_done >= 0) begin
        check($sformatf("exh_spacing_%0d", idx), cyc - last_done, 11);
      end
      last_done = cyc;
      if (idx < 255) begin
        bus.data_in_1 = 4'((idx + 1) >> 4);
        bus.data_in_2 = 4'(idx + 1);
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
